usb_rx_decoder: RTL and testbench

USB_RX_DECODER -- requirements
Module: usb_rx_decoder

---
 rtl/usb_rx_decoder_if.sv | 20 ++
 rtl/usb_rx_decoder.sv | 183 ++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_decoder_if.sv
// USB receive-side signal bundle: raw D+/D- lines in, decoded byte stream and status strobes out.
interface usb_rx_decoder_if;
    logic       d_plus_in;
    logic       d_minus_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;

    modport master (
        input  d_plus_in, d_minus_in,
        output rx_data, rx_valid, rx_active, rx_eop, rx_error
    );

    modport slave (
        output d_plus_in, d_minus_in,
        input  rx_data, rx_valid, rx_active, rx_eop, rx_error
    );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB full-speed style receive decoder: line sync, bit timing, NRZI decode, SYNC match,
// bit unstuffing, byte assembly and EOP/error detection with one-cycle status strobes.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic             clk,
    input  logic             rst,
    usb_rx_decoder_if.master bus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_SMP  = TW'(SAMPLE_POINT);

    typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP, ERR_WAIT} state_t;

    state_t          state;
    logic            dp_p0, dp_p1, dp_p2;
    logic            dm_p0, dm_p1;
    logic [TW-1:0]   timer;
    logic            prev_lvl;
    logic [2:0]      sync_cnt;
    logic [2:0]      bit_cnt;
    logic [2:0]      ones_cnt;
    logic [2:0]      j_cnt;
    logic            se0_two;
    logic            se0_seen;
    logic [6:0]      shreg;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q, rx_active_q, rx_eop_q, rx_error_q;

    logic line_j, line_k, line_se0, line_se1, line_jk;
    logic sample, dbit, edge_dp, fault;

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synced D+ for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_p0 <= 1'b1;
            dp_p1 <= 1'b1;
            dp_p2 <= 1'b1;
            dm_p0 <= 1'b0;
            dm_p1 <= 1'b0;
        end else begin
            dp_p0 <= bus.d_plus_in;
            dp_p1 <= dp_p0;
            dp_p2 <= dp_p1;
            dm_p0 <= bus.d_minus_in;
            dm_p1 <= dm_p0;
        end
    end

    always_comb begin
        line_j   = dp_p1 & ~dm_p1;
        line_k   = ~dp_p1 & dm_p1;
        line_se0 = ~dp_p1 & ~dm_p1;
        line_se1 = dp_p1 & dm_p1;
        line_jk  = line_j | line_k;
        edge_dp  = dp_p1 ^ dp_p2;
        sample   = (state != IDLE) && (timer == T_SMP);
        dbit     = (dp_p1 == prev_lvl);
        fault    = 1'b0;
        if (sample) begin
            case (state)
                SYNC:    fault = line_se1 | line_se0 | (dbit != (sync_cnt == 3'd7));
                RECEIVE: fault = line_se1 | (line_se0 && bit_cnt != 3'd0)
                               | (line_jk && ones_cnt == 3'd6 && dbit);
                EOP:     fault = line_se1 | line_k | (line_se0 && se0_two)
                               | (line_j && !se0_two);
                default: fault = 1'b0;
            endcase
        end
    end

    // Stage p1 -> outputs: receive FSM with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            prev_lvl    <= 1'b1;
            sync_cnt    <= '0;
            bit_cnt     <= '0;
            ones_cnt    <= '0;
            j_cnt       <= '0;
            se0_two     <= 1'b0;
            se0_seen    <= 1'b0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_error_q <= 1'b0;
            if (edge_dp || timer == T_LAST)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (fault) begin
                state       <= ERR_WAIT;
                rx_error_q  <= 1'b1;
                rx_active_q <= 1'b0;
                j_cnt       <= '0;
                se0_seen    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        timer    <= '0;
                        prev_lvl <= 1'b1;
                        if (line_k) begin
                            state    <= SYNC;
                            sync_cnt <= '0;
                        end
                    end
                    SYNC: if (sample) begin
                        prev_lvl <= dp_p1;
                        sync_cnt <= sync_cnt + 3'd1;
                        if (sync_cnt == 3'd7) begin
                            state       <= RECEIVE;
                            rx_active_q <= 1'b1;
                            ones_cnt    <= 3'd1;
                            bit_cnt     <= '0;
                        end
                    end
                    RECEIVE: if (sample) begin
                        if (line_se0) begin
                            state   <= EOP;
                            se0_two <= 1'b0;
                        end else begin
                            prev_lvl <= dp_p1;
                            // Six ones in a row: this bit is a stuffed 0 and carries no data.
                            if (ones_cnt == 3'd6) begin
                                ones_cnt <= '0;
                            end else begin
                                ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
                                shreg    <= {dbit, shreg[6:1]};
                                bit_cnt  <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    rx_data_q  <= {dbit, shreg};
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    EOP: if (sample) begin
                        if (line_se0) begin
                            se0_two <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            rx_eop_q    <= 1'b1;
                            rx_active_q <= 1'b0;
                            prev_lvl    <= 1'b1;
                            timer       <= '0;
                        end
                    end
                    ERR_WAIT: if (sample) begin
                        if (line_j) begin
                            if (se0_seen || j_cnt == 3'd7) begin
                                state    <= IDLE;
                                prev_lvl <= 1'b1;
                                timer    <= '0;
                            end else begin
                                j_cnt <= j_cnt + 3'd1;
                            end
                        end else begin
                            se0_seen <= line_se0;
                            j_cnt    <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_active = rx_active_q;
    assign bus.rx_eop    = rx_eop_q;
    assign bus.rx_error  = rx_error_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// Scoreboard bench for usb_rx_decoder: an NRZI/bit-stuffing line encoder drives packets and
// expected strobes are queued, then matched against the DUT as they appear.
module tb_usb_rx_decoder;
    localparam int CPB = 8;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_got, mon_want;
    bit   saw_active;
    logic lvl;

    usb_rx_decoder_if bus();

    usb_rx_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(3)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Event code: {kind, data}; kind 1 = byte, 2 = EOP, 3 = error.
    always @(negedge tb_clk) begin
        if (bus.rx_active) saw_active = 1'b1;
        if (!rst && (bus.rx_valid || bus.rx_eop || bus.rx_error)) begin
            mon_got = {bus.rx_error ? 2'd3 : (bus.rx_eop ? 2'd2 : 2'd1),
                       bus.rx_valid ? bus.rx_data : 8'h00};
            check("one_strobe", 32'(bus.rx_valid) + 32'(bus.rx_eop) + 32'(bus.rx_error), 1);
            if (bus.rx_eop || bus.rx_error) check("active_drop", 32'(bus.rx_active), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_got), 0);
            end else begin
                mon_want = exp_q.pop_front();
                check("event", 32'(mon_got), 32'(mon_want));
            end
        end
    end

    task automatic bit_time(input logic dp, input logic dm);
        bus.d_plus_in  = dp;
        bus.d_minus_in = dm;
        repeat (CPB) @(posedge tb_clk);
        #1;
    endtask

    task automatic nrzi(input bit b);
        if (!b) lvl = ~lvl;
        bit_time(lvl, ~lvl);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        repeat (n) bit_time(1'b1, 1'b0);
    endtask

    task automatic send_packet(input logic [15:0] payload, input int nbits,
                               input bit omit_stuff, input bit do_eop, input bit sync_ok);
        int ones;
        bit omitted;
        lvl = 1'b1;
        if (sync_ok) begin
            for (int i = 0; i < 8; i++) nrzi(i == 7);
            check("active_after_sync", 32'(bus.rx_active), 1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                lvl = (i % 2 == 1);
                bit_time(lvl, ~lvl);
            end
        end
        ones    = 1;
        omitted = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            nrzi(payload[i]);
            if (payload[i]) ones++;
            else ones = 0;
            if (ones == 6) begin
                if (omit_stuff && !omitted) omitted = 1'b1;
                else nrzi(1'b0);
                ones = 0;
            end
        end
        if (do_eop) begin
            bit_time(1'b0, 1'b0);
            bit_time(1'b0, 1'b0);
            lvl = 1'b1;
            bit_time(1'b1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.d_plus_in  = 1'b1;
        bus.d_minus_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_valid", 32'(bus.rx_valid), 0);
        check("rst_active", 32'(bus.rx_active), 0);
        check("rst_eop", 32'(bus.rx_eop), 0);
        check("rst_error", 32'(bus.rx_error), 0);
        check("rst_data", 32'(bus.rx_data), 0);
        rst = 1'b0;
        idle(4);

        // Two plain bytes and a clean EOP.
        exp_q.push_back({2'd1, 8'hA5});
        exp_q.push_back({2'd1, 8'h3C});
        exp_q.push_back({2'd2, 8'h00});
        send_packet(16'h3CA5, 16, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("hold_data", 32'(bus.rx_data), 32'h3C);
        check("idle_active", 32'(bus.rx_active), 0);
        check("q_empty_basic", exp_q.size(), 0);

        // All-ones bytes with stuffing, then the same with one stuff bit missing.
        exp_q.push_back({2'd1, 8'hFF});
        exp_q.push_back({2'd1, 8'hFF});
        exp_q.push_back({2'd2, 8'h00});
        send_packet(16'hFFFF, 16, 1'b0, 1'b1, 1'b1);
        idle(4);
        exp_q.push_back({2'd3, 8'h00});
        send_packet(16'hFFFF, 16, 1'b1, 1'b1, 1'b1);
        idle(12);
        check("q_empty_stuff", exp_q.size(), 0);

        // Partial byte before EOP, then a good packet.
        exp_q.push_back({2'd3, 8'h00});
        send_packet(16'h000A, 4, 1'b0, 1'b1, 1'b1);
        idle(12);
        exp_q.push_back({2'd1, 8'h12});
        exp_q.push_back({2'd2, 8'h00});
        send_packet(16'h0012, 8, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("data_after_partial", 32'(bus.rx_data), 32'h12);

        // Corrupted SYNC never raises rx_active.
        saw_active = 1'b0;
        exp_q.push_back({2'd3, 8'h00});
        send_packet(16'h0000, 0, 1'b0, 1'b0, 1'b0);
        idle(12);
        check("bad_sync_active", 32'(saw_active), 0);
        check("q_empty_sync", exp_q.size(), 0);

        // Reset in the middle of the 5th data bit.
        send_packet(16'h0055, 4, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge tb_clk);
        #1;
        check("active_before_rst", 32'(bus.rx_active), 1);
        rst = 1'b1;
        bus.d_plus_in  = 1'b1;
        bus.d_minus_in = 1'b0;
        @(posedge tb_clk);
        #1;
        check("midrst_active", 32'(bus.rx_active), 0);
        check("midrst_data", 32'(bus.rx_data), 0);
        check("midrst_strobes", 32'({bus.rx_valid, bus.rx_eop, bus.rx_error}), 0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        idle(10);
        check("q_empty_rst", exp_q.size(), 0);
        exp_q.push_back({2'd1, 8'h80});
        exp_q.push_back({2'd2, 8'h00});
        send_packet(16'h0080, 8, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("data_after_rst", 32'(bus.rx_data), 32'h80);
        check("q_empty_final", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
